sparrow_mem_responder: RTL
==========================

// Module: sparrow_mem_responder
// PURPOSE
// - Memory-side responder for the sparrow core's instruction and data memory interfaces.
// - Unified word array with one read-only instruction port and one read/write data port.
// - Includes a host boot-loader stream port that fills the array, then releases the core from reset.
// - Sits beside sparrow_top in the SoC/testbench; its clk is shared with the core.
// PARAMETERS
// - BASE_ADDR    32'h0000_0000  byte address of word 0
// - DEPTH_WORDS  8192           array depth in 32-bit words (power of 2)
// - BOOT_HOLD    1              1: hold core in reset until a load completes; 0: release after reset
// - TOHOST_ADDR  32'h0000_F000  MMIO halt register address (used only with SPARROW_MEM_TOHOST_EN)
// PORTS
// - clk                  in   1   clock
// - reset_n              in   1   async active-low reset
// - instr_mem_req_i      in   1   instruction fetch request
// - instr_mem_addr_i     in   32  fetch byte address
// - instr_mem_rd_data_o  out  32  fetched word (combinational)
// - data_mem_req_i       in   1   data access request
// - data_mem_addr_i      in   32  data byte address
// - data_mem_byte_en_i   in   2   access size: 00 byte, 01 half, 10 word, 11 reserved
// - data_mem_wr_i        in   1   1 = store, 0 = load
// - data_mem_wr_data_i   in   32  store data, right-justified
// - data_mem_rd_data_o   out  32  load data, right-justified, upper bits zero
// - load_start_i         in   1   pulse: begin a load at load_base_i
// - load_base_i          in   32  load start byte address (word aligned)
// - load_valid_i         in   1   load_data_i valid
// - load_data_i          in   32  load word
// - load_last_i          in   1   marks the final word of the load
// - load_ready_o         out  1   loader accepts a word
// - core_reset_n_o       out  1   active-low reset to sparrow_top
// - err_o                out  1   sticky access-error flag
// - tohost_o             out  32  last value written to TOHOST_ADDR (macro only)
// - halt_o               out  1   sticky; a write to TOHOST_ADDR occurred (macro only)
// BEHAVIOUR
// - Reset values:
//   - load_ready_o=0, err_o=0, tohost_o=0, halt_o=0.
//   - core_reset_n_o=0. Array contents are not reset.
// - Reads:
//   - Combinational from the array. Address index = (addr-BASE_ADDR)>>2.
//   - With req low, read data is 0.
//   - Loads select a lane by addr[1:0] and shift it to the LSBs.
// - Writes:
//   - Committed at posedge when data_mem_req_i & data_mem_wr_i & core_reset_n_o.
//   - Byte/half taken from wr_data LSBs and placed in the lane selected by addr[1:0]; other lanes are preserved.
// - Same-cycle fetch and store to the same word: the fetch returns the old value.
// - Errors:
//   - Out of range, misaligned (half with addr[0]=1; word with addr[1:0]!=0), or byte_en=11.
//   - On an error: read returns 0, write is dropped, err_o sets next cycle (sticky until reset).
//   - A fetch out of range or with addr[1:0]!=0 also sets err_o and returns 0.
// - Loader FSM:
//   - States IDLE -> LOAD -> RELEASE -> IDLE.
//   - IDLE:
//     - load_start_i captures the base into a word pointer and moves to LOAD.
//     - If BOOT_HOLD=0, core_reset_n_o goes to 1 on the first cycle after reset deassertion.
//   - LOAD:
//     - core_reset_n_o=0, load_ready_o=1.
//     - On valid&ready: write the word and increment the pointer.
//     - The pointer wraps modulo DEPTH_WORDS.
//     - If load_last_i, go to RELEASE.
//   - RELEASE:
//     - load_ready_o=0, core_reset_n_o stays 0 for this one cycle, then IDLE with core_reset_n_o=1 (registered).
//   - load_start_i is ignored outside IDLE. A start in IDLE after boot re-enters LOAD and reasserts core_reset_n_o.
//   - While core_reset_n_o=0: fetch data is 32'h0000_0013 (NOP), load data is 0, core writes are ignored.
// - reset_n mid-load: FSM to IDLE, pointer cleared, core held. Words already written remain.
// CONFIGURATION
// - SPARROW_MEM_TOHOST_EN defined:
//   - A word store to TOHOST_ADDR updates tohost_o and sets halt_o. The array is not written.
//   - A load from TOHOST_ADDR returns tohost_o.
// - SPARROW_MEM_TOHOST_EN undefined: no such ports; TOHOST_ADDR is ordinary array space.
// STRUCTURE
// - sparrow_pkg gains:
//   - mem_size_e {MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10}
//   - loader_state_e {LD_IDLE, LD_LOAD, LD_RELEASE}
//   - localparam RV_NOP = 32'h0000_0013
// - Sub-module sparrow_mem_loader: FSM, word pointer, ready/reset outputs; it drives a write strobe into the array.
// TESTING
// - Boot: start base 0x1000, words A,B,C with last on C, valid held high:
//   - ready high 3 cycles; 0x1000/4/8 hold A/B/C
//   - core_reset_n_o rises 2 cycles after C accepted
// - Byte store: 0xAB to 0x1001 over word 0x11223344 -> word 0x1122AB44; byte load 0x1001 -> 0x000000AB.
// - Half load at 0x1002 of 0x11223344 -> 0x00001122; half load at 0x1003 -> 0, err_o=1, and a later store leaves err_o at 1.
// - Store to BASE_ADDR+4*DEPTH_WORDS: dropped, err_o=1; a fetch during boot hold returns 0x00000013.
// - reset_n pulsed after 2 of 4 load words: FSM idle, core_reset_n_o=0; the 2 words persist; a restart load completes normally.
// - Macro: word store 0x1 to TOHOST_ADDR -> tohost_o=1, halt_o=1, array word unchanged (check with macro undefined too).

Source files
------------

// File: rtl/sparrow_pkg.sv
// Shared sparrow types: memory access sizes, boot-loader states and common constants.
package sparrow_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LOAD,
    LD_RELEASE
  } loader_state_e;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  function automatic logic [31:0] mem_size_mask(input logic [1:0] size);
    case (size)
      MEM_BYTE: return 32'h0000_00FF;
      MEM_HALF: return 32'h0000_FFFF;
      default:  return '1;
    endcase
  endfunction

  // Reserved size code 2'b11 counts as a bad access.
  function automatic logic mem_access_bad(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      MEM_BYTE: return 1'b0;
      MEM_HALF: return lsb[0];
      MEM_WORD: return lsb != 2'b00;
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/sparrow_mem_loader.sv
// Boot-loader FSM: streams host words into the array, then releases the core from reset.
module sparrow_mem_loader
  import sparrow_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 8192,
  parameter int unsigned BOOT_HOLD   = 1,
  localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load_start,
  input  logic [31:0]   load_base,
  input  logic          load_valid,
  input  logic          load_last,
  output logic          load_ready,
  output logic          core_reset_n,
  output logic          wr_en,
  output logic [AW-1:0] wr_idx
);

  loader_state_e state;
  logic [AW-1:0] ptr;
  logic          booted;

  assign wr_en  = load_ready & load_valid;
  assign wr_idx = ptr;

  // Release happens from IDLE once booted, so the core sees reset drop two
  // cycles after the last word is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= LD_IDLE;
      ptr          <= '0;
      booted       <= 1'b0;
      load_ready   <= 1'b0;
      core_reset_n <= 1'b0;
    end else begin
      case (state)
        LD_IDLE: begin
          if (load_start) begin
            ptr          <= AW'((load_base - BASE_ADDR) >> 2);
            state        <= LD_LOAD;
            load_ready   <= 1'b1;
            core_reset_n <= 1'b0;
          end else if (booted || BOOT_HOLD == 0) begin
            core_reset_n <= 1'b1;
          end
        end
        LD_LOAD: begin
          if (load_valid) begin
            ptr <= ptr + 1'b1;
            if (load_last) begin
              state      <= LD_RELEASE;
              load_ready <= 1'b0;
            end
          end
        end
        LD_RELEASE: begin
          state  <= LD_IDLE;
          booted <= 1'b1;
        end
        default: state <= LD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sparrow_mem_responder.sv
// Unified instruction/data memory for the sparrow core with host boot loader.
// Optional MMIO halt register enabled by defining SPARROW_MEM_TOHOST_EN.
module sparrow_mem_responder
  import sparrow_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 8192,
  parameter int unsigned BOOT_HOLD   = 1,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_F000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_mem_req_i,
  input  logic [31:0] instr_mem_addr_i,
  output logic [31:0] instr_mem_rd_data_o,
  input  logic        data_mem_req_i,
  input  logic [31:0] data_mem_addr_i,
  input  logic [1:0]  data_mem_byte_en_i,
  input  logic        data_mem_wr_i,
  input  logic [31:0] data_mem_wr_data_i,
  output logic [31:0] data_mem_rd_data_o,
  input  logic        load_start_i,
  input  logic [31:0] load_base_i,
  input  logic        load_valid_i,
  input  logic [31:0] load_data_i,
  input  logic        load_last_i,
  output logic        load_ready_o,
  output logic        core_reset_n_o,
  output logic        err_o
`ifdef SPARROW_MEM_TOHOST_EN
  ,
  output logic [31:0] tohost_o,
  output logic        halt_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];

  logic          ld_wr_en;
  logic [AW-1:0] ld_idx;

  logic [31:0]   f_off, d_off;
  logic [AW-1:0] f_idx, d_idx;
  logic          f_bad, d_bad, d_active, tohost_hit, core_wr, err_set;
  logic [4:0]    lane_sh;
  logic [31:0]   size_mask, wr_mask, d_word, wr_word, tohost_rd;

  sparrow_mem_loader #(
    .BASE_ADDR  (BASE_ADDR),
    .DEPTH_WORDS(DEPTH_WORDS),
    .BOOT_HOLD  (BOOT_HOLD)
  ) u_loader (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_start  (load_start_i),
    .load_base   (load_base_i),
    .load_valid  (load_valid_i),
    .load_last   (load_last_i),
    .load_ready  (load_ready_o),
    .core_reset_n(core_reset_n_o),
    .wr_en       (ld_wr_en),
    .wr_idx      (ld_idx)
  );

  assign f_off = instr_mem_addr_i - BASE_ADDR;
  assign d_off = data_mem_addr_i - BASE_ADDR;
  assign f_idx = AW'(f_off >> 2);
  assign d_idx = AW'(d_off >> 2);

`ifdef SPARROW_MEM_TOHOST_EN
  assign tohost_hit = (data_mem_addr_i == TOHOST_ADDR) && (data_mem_byte_en_i == MEM_WORD);
  assign tohost_rd  = tohost_o;
`else
  // Without the halt register the address is ordinary array space.
  assign tohost_hit = 1'b0 && (data_mem_addr_i == TOHOST_ADDR);
  assign tohost_rd  = '0;
`endif

  always_comb begin
    f_bad     = ((f_off >> 2) >= DEPTH_WORDS) || (f_off[1:0] != 2'b00);
    d_bad     = (((d_off >> 2) >= DEPTH_WORDS) || mem_access_bad(data_mem_byte_en_i, d_off[1:0]))
                && !tohost_hit;
    d_active  = data_mem_req_i && core_reset_n_o;
    lane_sh   = {d_off[1:0], 3'b000};
    size_mask = mem_size_mask(data_mem_byte_en_i);
    d_word    = mem[d_idx];
    wr_mask   = size_mask << lane_sh;
    wr_word   = (d_word & ~wr_mask) | ((data_mem_wr_data_i << lane_sh) & wr_mask);
    core_wr   = d_active && data_mem_wr_i && !d_bad && !tohost_hit;
    err_set   = core_reset_n_o && ((data_mem_req_i && d_bad) || (instr_mem_req_i && f_bad));

    instr_mem_rd_data_o = '0;
    if (instr_mem_req_i) begin
      if (!core_reset_n_o)  instr_mem_rd_data_o = RV_NOP;
      else if (!f_bad)      instr_mem_rd_data_o = mem[f_idx];
    end

    data_mem_rd_data_o = '0;
    if (d_active && !data_mem_wr_i) begin
      if (tohost_hit)       data_mem_rd_data_o = tohost_rd;
      else if (!d_bad)      data_mem_rd_data_o = (d_word >> lane_sh) & size_mask;
    end
  end

  // Loader and core writes never coincide: the core is held in reset while loading.
  always_ff @(posedge clk) begin
    if (ld_wr_en)     mem[ld_idx] <= load_data_i;
    else if (core_wr) mem[d_idx]  <= wr_word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_o <= 1'b0;
    else if (err_set) err_o <= 1'b1;
  end

`ifdef SPARROW_MEM_TOHOST_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tohost_o <= '0;
      halt_o   <= 1'b0;
    end else if (d_active && data_mem_wr_i && tohost_hit) begin
      tohost_o <= data_mem_wr_data_i;
      halt_o   <= 1'b1;
    end
  end
`endif

endmodule
